// File: rtl/proc_run_ctrl_if.sv
// proc_run_ctrl_if
//   Bundles the command handshake, the SingleCycleProc hookup and the
//   result FIFO port of proc_run_ctrl into one interface.
//   master : environment side (issues commands, models the core, consumes results)
//   slave  : proc_run_ctrl side
// Signals
//   start_valid/start_ready/start_pc/run_cycles/sample_count : run command
//   core_Reset_L/core_startPC/core_dMemOut                   : core hookup
//   res_valid/res_ready/res_data                             : result FIFO head
//   busy/overflow                                            : status
interface proc_run_ctrl_if #(
  parameter int DW = 32,
  parameter int CW = 16,
  parameter int SW = 5
);
  logic          start_valid;
  logic          start_ready;
  logic [DW-1:0] start_pc;
  logic [CW-1:0] run_cycles;
  logic [SW-1:0] sample_count;
  logic          core_Reset_L;
  logic [DW-1:0] core_startPC;
  logic [DW-1:0] core_dMemOut;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          overflow;

  modport master (
    output start_valid, start_pc, run_cycles, sample_count, core_dMemOut, res_ready,
    input  start_ready, core_Reset_L, core_startPC, res_valid, res_data, busy, overflow
  );

  modport slave (
    input  start_valid, start_pc, run_cycles, sample_count, core_dMemOut, res_ready,
    output start_ready, core_Reset_L, core_startPC, res_valid, res_data, busy, overflow
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
//   Run controller for SingleCycleProc. A command (start PC, cycle budget,
//   sample count) pulses the core's active-low reset for one cycle with the
//   PC applied, lets the core run for the budget, then captures dMemOut on
//   consecutive cycles into a result FIFO read by a consumer.
// Ports
//   CLK   : clock, everything on the rising edge
//   Reset : synchronous active-high reset, flushes FIFO and aborts any run
//   bus   : proc_run_ctrl_if.slave (command, core hookup, results, status)
module proc_run_ctrl #(
  parameter int DW    = 32,
  parameter int CW    = 16,
  parameter int DEPTH = 16,
  parameter int SW    = 5
) (
  input  logic           CLK,
  input  logic           Reset,
  proc_run_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CRST, RUN, SAMPLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] pc_q;
  logic [CW-1:0] run_q;
  logic [SW-1:0] samp_q;
  logic          accept, push, pop, full, wr_en;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SW:0]   count;
  logic          overflow_q;

  assign accept = bus.start_valid && (state == IDLE);
  assign full   = (count == (SW+1)'(DEPTH));
  assign pop    = (count != '0) && bus.res_ready;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign wr_en  = push && (!full || pop);

  assign bus.start_ready  = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  // Reset feeds straight through so the core is held for as long as Reset is high.
  assign bus.core_Reset_L = !Reset && (state != CRST);
  assign bus.core_startPC = pc_q;
  assign bus.res_valid    = (count != '0);
  assign bus.res_data     = mem[rd_ptr];
  assign bus.overflow     = overflow_q;

  // State, shared cycle counter and latched command fields.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pc_q   <= '0;
      run_q  <= '0;
      samp_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        pc_q   <= bus.start_pc;
        run_q  <= bus.run_cycles;
        samp_q <= bus.sample_count;
      end
    end
  end

  // Next-state logic. One counter is reused: it counts run edges in RUN,
  // then restarts at zero and counts pushes in SAMPLE. Zero budgets or zero
  // samples skip their state entirely.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CRST;
          cnt_nxt   = '0;
        end
      end
      CRST: begin
        cnt_nxt = '0;
        if (run_q != '0)       state_nxt = RUN;
        else if (samp_q != '0) state_nxt = SAMPLE;
        else                   state_nxt = IDLE;
      end
      RUN: begin
        if (cnt + CW'(1) == run_q) begin
          cnt_nxt = '0;
          if (samp_q != '0) state_nxt = SAMPLE;
          else              state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SAMPLE: begin
        push = 1'b1;
        if (cnt + CW'(1) == CW'(samp_q)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO pointers, occupancy and the sticky drop flag. Occupancy is kept
  // separately from the pointers so full and empty are distinguishable when
  // the pointers coincide.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + (SW+1)'(1);
      else if (!wr_en && pop) count <= count - (SW+1)'(1);
      if (accept)                     overflow_q <= 1'b0;
      else if (push && full && !pop)  overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset; the pointers and occupancy define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= bus.core_dMemOut;
  end

endmodule
